halfword_packer: RTL

Assembles pairs of 16-bit halfwords into 32-bit words for the LCD controller datapath, the write-side counterpart of the 32-to-16 half-select stage. Halfwords arrive low half first (`sel`=0 → bits [15:0]), then high half (`sel`=1 → bits [31:16]); the completed word is presented on a valid/ready output port. Out-of-order halves are flagged and dropped, and a delivered-word counter supports debug readback.

---
 rtl/lcd_pkg.sv | 14 +
 rtl/halfword_packer.sv | 93 +++++++++
 2 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD controller datapath: packer FSM states and
// halfword index constants also used by the 32-to-16 half-select decoder.
package lcd_pkg;

  typedef enum logic [1:0] {
    S_LO  = 2'd0,
    S_HI  = 2'd1,
    S_OUT = 2'd2
  } pack_state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/halfword_packer.sv
// Packs low-then-high halfword pairs into full words on a valid/ready port,
// flagging and dropping out-of-order halves and counting delivered words.
module halfword_packer
  import lcd_pkg::*;
#(
  parameter int HALF_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  sel,
  input  logic [HALF_W-1:0]     data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*HALF_W-1:0]   data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err,
  output logic [CNT_W-1:0]      word_cnt
);

  pack_state_t       state_reg;
  logic [HALF_W-1:0] lo_reg;
  logic              accept;

  // A held word blocks input unless it drains in the same cycle.
  assign in_ready = en && !clr && (state_reg != S_OUT || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_LO;
      lo_reg    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
    end else begin
      err <= 1'b0;
      if (clr) begin
        state_reg <= S_LO;
        lo_reg    <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state_reg)
          S_LO: begin
            if (accept) begin
              if (sel == HALF_LO) begin
                lo_reg    <= data_in;
                state_reg <= S_HI;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_HI: begin
            if (accept) begin
              if (sel == HALF_HI) begin
                data_out  <= {data_in, lo_reg};
                out_valid <= 1'b1;
                state_reg <= S_OUT;
              end else begin
                lo_reg <= data_in;
                err    <= 1'b1;
              end
            end
          end
          S_OUT: begin
            if (out_ready) begin
              word_cnt  <= word_cnt + CNT_W'(1);
              out_valid <= 1'b0;
              // Delivery may overlap with the next low half to avoid a bubble.
              if (accept && sel == HALF_LO) begin
                lo_reg    <= data_in;
                state_reg <= S_HI;
              end else begin
                err       <= accept;
                state_reg <= S_LO;
              end
            end
          end
          default: begin
            state_reg <= S_LO;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
